cache_arbiter: RTL and testbench

- Shares the single physical-memory line port between the instruction cache and the data cache. Both caches are built on the same cache_control/datapath pair.
- Each cache holds its pmem request until it gets a response. The arbiter grants one owner, latches that owner's transaction, drives main memory (cacheline adaptor side) and routes the response back.
- Sits between the two caches and the cacheline adaptor at the top of the memory hierarchy.

---
 rtl/cache_arb_pkg.sv | 7 +
 rtl/cache_arb_pick.sv | 16 +
 rtl/cache_arbiter.sv | 79 +++++++
 tb/tb_cache_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and widths for the icache/dcache pmem arbiter
package cache_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} arb_state_t;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} requester_t;
endpackage

// File: rtl/cache_arb_pick.sv
// cache_arb_pick: round-robin pick between icache and dcache requests
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  requester_t last_grant,
  output logic       grant_valid,
  output requester_t grant_id
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = (i_req & d_req) ? ((last_grant == REQ_I) ? REQ_D : REQ_I)
                                  : (d_req ? REQ_D : REQ_I);
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the physical-memory line port between icache and dcache
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int LINE_WIDTH = LINE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  busy
);
  arb_state_t            r_state, w_next;
  requester_t            r_last, w_gid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_write;
  logic                  w_gv, w_grant, w_d_req, w_serving;
  assign w_d_req = d_pmem_read | d_pmem_write;
  cache_arb_pick u_pick (
    .i_req      (i_pmem_read),
    .d_req      (w_d_req),
    .last_grant (r_last),
    .grant_valid(w_gv),
    .grant_id   (w_gid)
  );
  assign w_grant     = (r_state == IDLE) & w_gv;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:             w_next = w_gv ? ((w_gid == REQ_D) ? SERVE_D : SERVE_I) : IDLE;
      SERVE_I, SERVE_D: w_next = mem_resp ? RECOVER : r_state;
      default:          w_next = IDLE;
    endcase
    w_serving    = (r_state == SERVE_I) | (r_state == SERVE_D);
    mem_read     = w_serving & ~r_write;
    mem_write    = w_serving & r_write;
    i_pmem_resp  = (r_state == SERVE_I) & mem_resp;
    d_pmem_resp  = (r_state == SERVE_D) & mem_resp;
    i_pmem_rdata = (r_state == SERVE_I) ? mem_rdata : '0;
    d_pmem_rdata = (r_state == SERVE_D) ? mem_rdata : '0;
    busy         = r_state != IDLE;
  end
  // a dcache read+write request is a write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= REQ_I;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last  <= w_gid;
        r_addr  <= (w_gid == REQ_D) ? d_pmem_address : i_pmem_address;
        r_wdata <= (w_gid == REQ_D) ? d_pmem_wdata : '0;
        r_write <= (w_gid == REQ_D) & d_pmem_write;
      end
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed, table-driven and randomized checks of cache_arbiter
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read, i_pmem_resp;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata, d_pmem_rdata;
  logic         mem_read, mem_write, mem_resp, busy;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " mem_read"}, mem_read, 1'b0);
    chk1({tag, " mem_write"}, mem_write, 1'b0);
    chk1({tag, " i_resp"}, i_pmem_resp, 1'b0);
    chk1({tag, " d_resp"}, d_pmem_resp, 1'b0);
  endtask

  // Entered at a negedge in IDLE with requests already driven; returns #1 into the resp cycle.
  task automatic serve(input int owner, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wd, input int dly, input logic [255:0] line,
                       input bit mutate);
    #1;
    idle_chk("arb");
    nxt();
    for (int k = 0; k < dly; k++) begin
      mem_resp = 1'b0;
      if (mutate && k == 1) begin
        d_pmem_address = 32'h0000_4000;
        i_pmem_read = 1'b1;
      end
      #1;
      chk1("srv mem_read", mem_read, !wr);
      chk1("srv mem_write", mem_write, wr);
      chk32("srv mem_address", mem_address, addr);
      if (wr) chk256("srv mem_wdata", mem_wdata, wd);
      chk1("srv busy", busy, 1'b1);
      chk1("srv i_resp", i_pmem_resp, 1'b0);
      chk1("srv d_resp", d_pmem_resp, 1'b0);
      nxt();
    end
    mem_resp = 1'b1;
    mem_rdata = line;
    #1;
    chk1("rsp mem_read", mem_read, !wr);
    chk1("rsp mem_write", mem_write, wr);
    chk32("rsp mem_address", mem_address, addr);
    chk1("rsp i_resp", i_pmem_resp, owner == 0);
    chk1("rsp d_resp", d_pmem_resp, owner == 1);
    if (owner == 0) chk256("rsp i_rdata", i_pmem_rdata, line);
    else chk256("rsp d_rdata", d_pmem_rdata, line);
  endtask

  task automatic rec(input logic stray);
    mem_resp = stray;
    #1;
    chk1("rec mem_read", mem_read, 1'b0);
    chk1("rec mem_write", mem_write, 1'b0);
    chk1("rec busy", busy, 1'b1);
    chk1("rec i_resp", i_pmem_resp, 1'b0);
    chk1("rec d_resp", d_pmem_resp, 1'b0);
  endtask

  typedef struct {
    logic ir, dr, dw;
    logic [31:0] ia, da;
    logic [255:0] wd;
    int owner;
    logic wr;
    logic [31:0] ea;
    int dly;
  } vec_t;
  vec_t vt[7];

  int m_owner, m_last, d_op;
  bit m_rec, m_wr, i_got, d_got, p_act, p_resp;
  logic [31:0] m_addr;
  logic [255:0] m_wd;

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 32'h8000, 32'h9000, 256'h0, 0, 1'b0, 32'h8000, 2};
    vt[1] = '{1'b1, 1'b0, 1'b1, 32'h8040, 32'h9040, {8{32'h3333_3333}}, 1, 1'b1, 32'h9040, 1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'h8080, 32'h9080, {8{32'h4444_4444}}, 1, 1'b1, 32'h9080, 3};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h80c0, 32'h90c0, 256'h0, 0, 1'b0, 32'h80c0, 0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 32'h8100, 32'h9100, 256'h0, 0, 1'b0, 32'h8100, 1};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'h8140, 32'h9140, 256'h0, 1, 1'b0, 32'h9140, 2};
    vt[6] = '{1'b0, 1'b0, 1'b0, 32'h8180, 32'h9180, 256'h0, -1, 1'b0, 32'h0, 0};

    // reset held with both caches requesting
    rst = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 32'h2000;
    d_pmem_read = 1'b0; d_pmem_write = 1'b1; d_pmem_address = 32'h3000;
    d_pmem_wdata = {8{32'h1234_5678}};
    mem_resp = 1'b1; mem_rdata = {8{32'hdead_beef}};
    repeat (2) begin
      nxt();
      #1;
      idle_chk("reset");
      chk32("reset mem_address", mem_address, 32'h0);
      chk256("reset mem_wdata", mem_wdata, 256'h0);
      chk256("reset i_rdata", i_pmem_rdata, 256'h0);
      chk256("reset d_rdata", d_pmem_rdata, 256'h0);
    end
    nxt();
    rst = 1'b0; mem_resp = 1'b0;
    // first tie goes to dcache; request changes during service are ignored
    serve(1, 1'b1, 32'h3000, {8{32'h1234_5678}}, 3, {8{32'h0bad_f00d}}, 1'b1);
    nxt();
    d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h3100;
    rec(1'b0);
    nxt();
    serve(0, 1'b0, 32'h2000, 256'h0, 2, {8{32'h1111_2222}}, 1'b0);
    nxt();
    i_pmem_read = 1'b0;
    rec(1'b1);
    nxt();
    serve(1, 1'b0, 32'h3100, 256'h0, 1, {8{32'h5555_aaaa}}, 1'b0);
    nxt();
    d_pmem_read = 1'b0;
    rec(1'b0);
    nxt();
    // lone icache read
    i_pmem_read = 1'b1; i_pmem_address = 32'h1000;
    serve(0, 1'b0, 32'h1000, 256'h0, 5, {32{8'hA5}}, 1'b0);
    nxt();
    i_pmem_read = 1'b0;
    rec(1'b0);
    nxt();
    // evict then load
    d_pmem_write = 1'b1; d_pmem_address = 32'h5000; d_pmem_wdata = {8{32'hcafe_0001}};
    serve(1, 1'b1, 32'h5000, {8{32'hcafe_0001}}, 2, {8{32'h0}}, 1'b0);
    nxt();
    d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h6000;
    rec(1'b0);
    nxt();
    serve(1, 1'b0, 32'h6000, 256'h0, 2, {8{32'h6060_6060}}, 1'b0);
    nxt();
    d_pmem_read = 1'b0;
    rec(1'b0);
    nxt();
    // arbitration table, last grant is dcache at this point
    for (int v = 0; v < 7; v++) begin
      i_pmem_read = vt[v].ir; d_pmem_read = vt[v].dr; d_pmem_write = vt[v].dw;
      i_pmem_address = vt[v].ia; d_pmem_address = vt[v].da; d_pmem_wdata = vt[v].wd;
      if (vt[v].owner < 0) begin
        #1; idle_chk("tbl none");
        nxt();
        #1; idle_chk("tbl none2");
        nxt();
      end else begin
        serve(vt[v].owner, vt[v].wr, vt[v].ea, vt[v].wd, vt[v].dly, {8{$urandom}}, 1'b0);
        nxt();
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        rec(1'b0);
        nxt();
      end
    end
    // reset during SERVE_I, then a fresh request completes
    i_pmem_read = 1'b1; i_pmem_address = 32'h7000;
    #1; nxt();
    #1; chk1("pre-rst mem_read", mem_read, 1'b1);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0; mem_resp = 1'b1;
    serve(0, 1'b0, 32'h7000, 256'h0, 2, {8{32'h7777_0000}}, 1'b0);
    nxt();
    i_pmem_read = 1'b0;
    rec(1'b0);
    nxt();

    // randomized traffic against a transaction-level reference
    rst = 1'b1; mem_resp = 1'b0;
    nxt();
    rst = 1'b0;
    m_owner = -1; m_last = 0; m_rec = 1'b0; m_wr = 1'b0; m_addr = '0; m_wd = '0;
    i_got = 1'b0; d_got = 1'b0; p_act = 1'b0; p_resp = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (i_got) i_pmem_read = ($urandom_range(0, 2) == 0);
      else if (!i_pmem_read) i_pmem_read = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) i_pmem_address = $urandom & 32'hffff_ffe0;
      if (d_got || !(d_pmem_read || d_pmem_write)) begin
        d_op = $urandom_range(0, 7);
        d_pmem_read = (d_op == 0) || (d_op == 2);
        d_pmem_write = (d_op == 1) || (d_op == 2);
      end
      if ($urandom_range(0, 3) == 0) d_pmem_address = $urandom & 32'hffff_ffe0;
      if ($urandom_range(0, 3) == 0) d_pmem_wdata = {8{$urandom}};
      mem_resp = (p_act && !p_resp) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 149) == 0);
      #1;
      chk1("rnd mem_read", mem_read, m_owner >= 0 && !m_wr);
      chk1("rnd mem_write", mem_write, m_owner >= 0 && m_wr);
      chk1("rnd busy", busy, m_owner >= 0 || m_rec);
      chk1("rnd i_resp", i_pmem_resp, m_owner == 0 && mem_resp);
      chk1("rnd d_resp", d_pmem_resp, m_owner == 1 && mem_resp);
      if (m_owner >= 0) chk32("rnd mem_address", mem_address, m_addr);
      if (m_owner >= 0 && m_wr) chk256("rnd mem_wdata", mem_wdata, m_wd);
      if (m_owner == 0 && mem_resp) chk256("rnd i_rdata", i_pmem_rdata, mem_rdata);
      if (m_owner == 1 && mem_resp) chk256("rnd d_rdata", d_pmem_rdata, mem_rdata);
      i_got = i_pmem_resp; d_got = d_pmem_resp;
      p_act = mem_read | mem_write; p_resp = mem_resp;
      if (rst) begin
        m_owner = -1; m_rec = 1'b0; m_last = 0;
      end else if (m_owner >= 0) begin
        if (mem_resp) begin m_owner = -1; m_rec = 1'b1; end
      end else if (m_rec) begin
        m_rec = 1'b0;
      end else begin
        if (i_pmem_read && (d_pmem_read || d_pmem_write)) m_owner = 1 - m_last;
        else if (d_pmem_read || d_pmem_write) m_owner = 1;
        else if (i_pmem_read) m_owner = 0;
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_addr = (m_owner == 1) ? d_pmem_address : i_pmem_address;
          m_wr = (m_owner == 1) && d_pmem_write;
          m_wd = d_pmem_wdata;
        end
      end
      nxt();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
